sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, number of storage entries; DEPTH is a power of two and at least 4.
REQ-003 The block SHALL have parameter AF_LEVEL, default 28, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, occupancy at or below which almost_empty asserts; legal range 0..DEPTH-1.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic samples on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port wr, input, 1, write request.
REQ-008 The block SHALL have port data_in, input, WIDTH, write data.
REQ-009 The block SHALL have port rd, input, 1, read request.
REQ-010 The block SHALL have port flush, input, 1, synchronous empty-the-FIFO command.
REQ-011 The block SHALL have port data_out, output, WIDTH, registered read data.
REQ-012 The block SHALL have port rd_valid, output, 1, one-cycle pulse marking new data_out.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1, occupancy flags.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-015 The block SHALL have ports overflow and underflow, each output, 1, sticky error flags.

Function
REQ-016 The block SHALL accept a write when wr=1 and (full=0 or a read is accepted in the same cycle), storing data_in at the tail.
REQ-017 The block SHALL accept a read when rd=1 and empty=0; there is no write-to-read bypass when empty.
REQ-018 On an accepted read, the block SHALL drive data_out with the head entry and rd_valid=1 on the following cycle; otherwise rd_valid=0 and data_out holds its value.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-020 Count SHALL increment on write-only, decrement on read-only, and hold on both or neither.
REQ-021 The flags SHALL be decoded from registered count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-022 When full and wr=1 and rd=1, both operations SHALL be accepted and count SHALL remain DEPTH.
REQ-023 When empty and wr=1 and rd=1, the write SHALL be accepted, the read rejected, and count SHALL become 1.
REQ-024 A wr that is not accepted SHALL set overflow, and it SHALL remain set until rst or flush.
REQ-025 An rd that is not accepted SHALL set underflow, and it SHALL remain set until rst or flush.
REQ-026 flush=1 SHALL take priority over rd and wr, zero pointers, count, rd_valid, overflow and underflow, retain data_out, and leave memory contents unchanged.
REQ-027 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-028 rst=1 at a clock edge SHALL zero data_out, pointers, count, rd_valid, overflow and underflow; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Reset SHALL take priority over flush, rd and wr; memory array contents are not reset.

Structure
REQ-030 Package sync_fifo_pkg SHALL hold default WIDTH/DEPTH/threshold constants and a parameter-legality check function.
REQ-031 The storage array SHALL be a sub-module sync_fifo_mem (one write port, one registered read port); pointer, count and flag logic SHALL live in sync_fifo_param.

Verification (WIDTH=8, DEPTH=32, AF=28, AE=4)
REQ-032 Reset, then write 0x00..0x1F -> almost_full at count 28, full at 32; a 33rd write sets overflow and count stays 32.
REQ-033 Read 32 times -> data_out 0x00..0x1F in order, each one cycle after rd, with rd_valid pulses; empty after the last read; an extra rd sets underflow, rd_valid=0 and data_out holds 0x1F.
REQ-034 Full plus rd and wr with 0xAA together -> count stays 32, data_out=oldest entry, overflow=0; after draining, 0xAA comes out last.
REQ-035 Empty plus rd and wr with 0x55 together -> count=1, rd_valid=0, underflow=1; the next rd returns 0x55.
REQ-036 Stream 100 words with occupancy held near 10 -> pointers wrap several times and output order matches input.
REQ-037 At count=17, pulse rst -> next cycle count=0, empty=1, data_out=0, flags clear; repeat with flush -> same, except data_out is retained.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and parameter checks
// for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_AF_LEVEL = 28;
  localparam int DEF_AE_LEVEL = 4;

  function automatic bit params_ok(
    input int width,
    input int depth,
    input int af,
    input int ae
  );
    bit pow2;
    pow2 = (depth > 0) &&
           ((depth & (depth - 1)) == 0);
    return (width >= 1) && pow2 &&
           (depth >= 4) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Request/response bundle between a FIFO
// user (master) and the FIFO (slave).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, data_in, rd, flush,
    input  data_out, rd_valid,
    input  full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd, flush,
    output data_out, rd_valid,
    output full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port and one
// registered read port; array not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port, storage keeps contents
  // across reset and flush
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, cleared only by reset
  always_ff @(posedge clock) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO: pointers, occupancy
// count, flags and sticky error bits.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic              clock,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!params_ok(WIDTH, DEPTH,
                 AF_LEVEL, AE_LEVEL))
  begin : g_bad_params
    $error("sync_fifo_param: bad params");
  end

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          rv_q;
  logic          ovf_q;
  logic          udf_q;
  logic          full_w;
  logic          empty_w;
  logic          rd_acc;
  logic          wr_acc;
  logic          mem_we;
  logic          mem_re;

  assign full_w  = (cnt == CW'(DEPTH));
  assign empty_w = (cnt == '0);

  // no bypass: a read needs a stored word;
  // a full FIFO still takes a write when
  // a read frees a slot in the same cycle
  assign rd_acc = bus.rd && !empty_w;
  assign wr_acc = bus.wr &&
                  (!full_w || rd_acc);

  assign mem_we = wr_acc && !rst &&
                  !bus.flush;
  assign mem_re = rd_acc && !bus.flush;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (bus.data_in),
    .re    (mem_re),
    .raddr (rptr),
    .rdata (bus.data_out)
  );

  // pointer, count and error-flag state
  always_ff @(posedge clock) begin
    if (rst || bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      rv_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      unique case (1'b1)
        (wr_acc && !rd_acc):
          cnt <= cnt + 1'b1;
        (rd_acc && !wr_acc):
          cnt <= cnt - 1'b1;
        default:
          cnt <= cnt;
      endcase
      rv_q <= rd_acc;
      if (bus.wr && !wr_acc)
        ovf_q <= 1'b1;
      if (bus.rd && !rd_acc)
        udf_q <= 1'b1;
    end
  end

  // flags decoded from registered count
  always_comb begin
    bus.count        = cnt;
    bus.full         = full_w;
    bus.empty        = empty_w;
    bus.almost_full  = (cnt >= CW'(AF_LEVEL));
    bus.almost_empty = (cnt <= CW'(AE_LEVEL));
    bus.rd_valid     = rv_q;
    bus.overflow     = ovf_q;
    bus.underflow    = udf_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param:
// vector table, directed corners, random.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  always #5 clock = ~clock;

  sync_fifo_param_if #(
    .WIDTH (W),
    .DEPTH (D)
  ) bus ();

  sync_fifo_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int total  = 0;
  int passed = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] m_dout = '0;
  bit           m_rv   = 1'b0;
  bit           m_ovf  = 1'b0;
  bit           m_udf  = 1'b0;

  typedef struct {
    bit           r;
    bit           w;
    logic [W-1:0] d;
    bit           rdi;
    bit           fl;
    int           cnt;
    bit           emp;
    bit           rv;
    logic [W-1:0] dout;
    bit           ovf;
    bit           udf;
  } vec_t;

  vec_t tbl [11];

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h need %0h",
                  name, act, exp);
  endtask

  task automatic model(
    input bit r, input bit w,
    input logic [W-1:0] d,
    input bit rdi, input bit fl
  );
    bit racc;
    bit wacc;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_rv = 0; m_ovf = 0; m_udf = 0;
    end else if (fl) begin
      q.delete();
      m_rv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      racc = rdi && (q.size() > 0);
      wacc = w && ((q.size() < D) || racc);
      m_rv = racc;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      if (w && !wacc) m_ovf = 1;
      if (rdi && !racc) m_udf = 1;
    end
  endtask

  task automatic step(
    input bit r, input bit w,
    input logic [W-1:0] d,
    input bit rdi, input bit fl
  );
    rst = r;
    bus.wr = w;
    bus.data_in = d;
    bus.rd = rdi;
    bus.flush = fl;
    @(posedge clock);
    #1;
    model(r, w, d, rdi, fl);
    rst = 0;
    bus.wr = 0;
    bus.rd = 0;
    bus.flush = 0;
  endtask

  task automatic check_all(input string t);
    int n;
    n = q.size();
    check({t, " count"}, bus.count, n);
    check({t, " full"}, bus.full, n == D);
    check({t, " empty"}, bus.empty, n == 0);
    check({t, " afull"}, bus.almost_full,
          n >= AF);
    check({t, " aempty"}, bus.almost_empty,
          n <= AE);
    check({t, " rd_valid"}, bus.rd_valid, m_rv);
    check({t, " data_out"}, bus.data_out,
          m_dout);
    check({t, " overflow"}, bus.overflow,
          m_ovf);
    check({t, " underflow"}, bus.underflow,
          m_udf);
  endtask

  initial begin
    int next_r;
    int next_w;
    int cyc;
    int occ;
    bit w;
    bit r;

    bus.wr = 0;
    bus.rd = 0;
    bus.flush = 0;
    bus.data_in = '0;

    // r w d rd fl | cnt emp rv dout ovf udf
    tbl[0]  = '{1,0,8'h00,0,0, 0,1,0,8'h00,0,0};
    tbl[1]  = '{0,1,8'hA1,0,0, 1,0,0,8'h00,0,0};
    tbl[2]  = '{0,1,8'hB2,0,0, 2,0,0,8'h00,0,0};
    tbl[3]  = '{0,0,8'h00,1,0, 1,0,1,8'hA1,0,0};
    tbl[4]  = '{0,0,8'h00,0,0, 1,0,0,8'hA1,0,0};
    tbl[5]  = '{0,1,8'hC3,1,0, 1,0,1,8'hB2,0,0};
    tbl[6]  = '{0,0,8'h00,1,0, 0,1,1,8'hC3,0,0};
    tbl[7]  = '{0,0,8'h00,1,0, 0,1,0,8'hC3,0,1};
    tbl[8]  = '{0,1,8'h55,1,0, 1,0,0,8'hC3,0,1};
    tbl[9]  = '{0,0,8'h00,0,1, 0,1,0,8'hC3,0,0};
    tbl[10] = '{1,1,8'h66,1,1, 0,1,0,8'h00,0,0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d,
           tbl[i].rdi, tbl[i].fl);
      check($sformatf("vec%0d count", i),
            bus.count, tbl[i].cnt);
      check($sformatf("vec%0d empty", i),
            bus.empty, tbl[i].emp);
      check($sformatf("vec%0d rd_valid", i),
            bus.rd_valid, tbl[i].rv);
      check($sformatf("vec%0d data_out", i),
            bus.data_out, tbl[i].dout);
      check($sformatf("vec%0d overflow", i),
            bus.overflow, tbl[i].ovf);
      check($sformatf("vec%0d underflow", i),
            bus.underflow, tbl[i].udf);
    end

    // fill to full, then overflow
    step(1, 0, 0, 0, 0);
    check_all("reset");
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'(i), 0, 0);
      check_all("fill");
      if (i == AF - 2)
        check("af below", bus.almost_full, 0);
      if (i == AF - 1)
        check("af at 28", bus.almost_full, 1);
      if (i == D - 2)
        check("full at 31", bus.full, 0);
      if (i == D - 1)
        check("full at 32", bus.full, 1);
    end
    step(0, 1, 8'h20, 0, 0);
    check("ovf set", bus.overflow, 1);
    check("ovf count", bus.count, D);
    check_all("ovf");

    // drain in order, then underflow
    for (int i = 0; i < D; i++) begin
      step(0, 0, 0, 1, 0);
      check("drain data", bus.data_out, i);
      check("drain valid", bus.rd_valid, 1);
      check_all("drain");
    end
    check("drained empty", bus.empty, 1);
    step(0, 0, 0, 1, 0);
    check("udf set", bus.underflow, 1);
    check("udf valid", bus.rd_valid, 0);
    check("udf hold", bus.data_out, 8'h1F);

    // full with simultaneous rd and wr
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < D; i++)
      step(0, 1, 8'(8'h40 + i), 0, 0);
    step(0, 1, 8'hAA, 1, 0);
    check("fullrw count", bus.count, D);
    check("fullrw data", bus.data_out, 8'h40);
    check("fullrw ovf", bus.overflow, 0);
    check_all("fullrw");
    for (int i = 0; i < D; i++) begin
      step(0, 0, 0, 1, 0);
      check_all("fullrw drain");
    end
    check("AA last", bus.data_out, 8'hAA);

    // empty with simultaneous rd and wr
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h55, 1, 0);
    check("emptyrw count", bus.count, 1);
    check("emptyrw valid", bus.rd_valid, 0);
    check("emptyrw udf", bus.underflow, 1);
    step(0, 0, 0, 1, 0);
    check("emptyrw data", bus.data_out, 8'h55);
    check("emptyrw rv", bus.rd_valid, 1);

    // stream 100 words at occupancy ~10
    step(1, 0, 0, 0, 0);
    next_w = 0;
    next_r = 0;
    cyc = 0;
    while (next_r < 100 && cyc < 2000) begin
      occ = q.size();
      w = (next_w < 100) && (occ < 12) &&
          ((occ < 8) || ($urandom_range(0, 1) == 1));
      r = (occ > 0) &&
          ((next_w >= 100) || (occ > 10) ||
           ((occ >= 8) &&
            ($urandom_range(0, 1) == 1)));
      step(0, w, 8'(next_w), r, 0);
      if (w) next_w++;
      check_all("stream");
      if (bus.rd_valid === 1'b1) begin
        check("stream order", bus.data_out,
              8'(next_r));
        next_r++;
      end
      cyc++;
    end
    check("stream words", next_r, 100);

    // reset and flush at count 17
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      step(0, 1, 8'(8'h80 + i), 0, 0);
    step(0, 1, 8'h91, 1, 0);
    check("pre rst count", bus.count, 17);
    step(1, 0, 0, 0, 0);
    check("rst count", bus.count, 0);
    check("rst empty", bus.empty, 1);
    check("rst data", bus.data_out, 0);
    check_all("rst17");
    for (int i = 0; i < 17; i++)
      step(0, 1, 8'(8'hC0 + i), 0, 0);
    step(0, 1, 8'hD1, 1, 0);
    check("pre fl count", bus.count, 17);
    step(0, 0, 0, 0, 1);
    check("fl count", bus.count, 0);
    check("fl empty", bus.empty, 1);
    check("fl data", bus.data_out, 8'hC0);
    check_all("flush17");

    // randomized traffic with rare rst/flush
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      int wp;
      wp = ((k / 100) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 99) < wp,
           8'($urandom),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 79) == 0);
      check_all("random");
    end

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule
